// File: rtl/cpu_ifetch.sv
// cpu_ifetch: instruction fetch stage feeding the CPU control unit.
// Keeps the PC, fetches 32-bit MIPS words over a req/ack memory handshake,
// holds each word in an instruction register and presents decoded fields to
// the controller with a valid/ready handshake. Branch/jump redirects are
// accepted in any state.
// Optional build macro: IFETCH_ALIGN_CHK_EN enables the misaligned-PC fault;
// without it the low address bits pass through unchecked and if_fault is 0.
module cpu_ifetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clrn,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [5:0]        op,
    output logic [5:0]        func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [15:0]       imm,
    output logic              if_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       ir;
    logic              drop;

    logic              launch;
    logic [ADDR_W-1:0] launch_addr;
    logic              misalign;
    logic              capture;

    assign imem_req  = (state == REQ);
    assign imem_addr = req_addr;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign func  = ir[5:0];
    assign imm   = ir[15:0];

    // A fresh request is due: pick the address the next request would use.
    always_comb begin
        launch      = 1'b0;
        launch_addr = req_addr;
        case (state)
            IDLE: begin
                launch      = 1'b1;
                launch_addr = redir_valid ? redir_pc : pc;
            end
            REQ: begin
                if (redir_valid && imem_ack) begin
                    // response arriving with a redirect is thrown away
                    launch      = 1'b1;
                    launch_addr = redir_pc;
                end else if (!redir_valid && imem_ack && drop) begin
                    // stale response from before a redirect; reissue at pc
                    launch      = 1'b1;
                    launch_addr = pc;
                end
            end
            HOLD: begin
                if (redir_valid) begin
                    launch      = 1'b1;
                    launch_addr = redir_pc;
                end else if (id_ready && !if_fault) begin
                    // a held fault is re-presented until redirect or reset
                    launch      = 1'b1;
                    launch_addr = pc;
                end
            end
            default: begin
                launch = 1'b0;
            end
        endcase
    end

`ifdef IFETCH_ALIGN_CHK_EN
    assign misalign = (launch_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A usable response: requested data arrived and nothing invalidated it.
    assign capture = (state == REQ) && imem_ack && !redir_valid && !drop;

    // Fetch FSM, PC and instruction register.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            ir       <= '0;
            id_pc    <= '0;
            drop     <= 1'b0;
            id_valid <= 1'b0;
            if_fault <= 1'b0;
        end else begin
            if (redir_valid) begin
                pc <= redir_pc;
            end else if (capture) begin
                pc <= req_addr + ADDR_W'(4);
            end

            if (launch) begin
                drop     <= 1'b0;
                req_addr <= launch_addr;
                if (misalign) begin
                    // present a nop-shaped fault instead of fetching
                    state    <= HOLD;
                    id_valid <= 1'b1;
                    ir       <= '0;
                    id_pc    <= launch_addr;
                    if_fault <= 1'b1;
                end else begin
                    state    <= REQ;
                    id_valid <= 1'b0;
                    if_fault <= 1'b0;
                end
            end else if (capture) begin
                ir       <= imem_rdata;
                id_pc    <= req_addr;
                id_valid <= 1'b1;
                state    <= HOLD;
            end else if (state == REQ && redir_valid) begin
                // outstanding request must complete; mark its data stale
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Self-checking bench for cpu_ifetch: a table of per-cycle vectors for the
// zero-wait fetch sequence plus hand-written redirect/stall/reset sequences.
// Delivered instructions are checked against a queue of expected addresses.
module tb_cpu_ifetch;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic        if_fault;

    // second instance with high reset PC, zero-wait memory, always ready
    logic        req_hi;
    logic [31:0] addr_hi;
    logic        ack_hi;
    logic [31:0] rdata_hi;
    logic        redir_hi = 1'b0;
    logic [31:0] redir_pc_hi = '0;
    logic        valid_hi;
    logic        ready_hi = 1'b1;
    logic [31:0] id_pc_hi;
    logic [5:0]  op_hi, func_hi;
    logic [4:0]  rs_hi, rt_hi, rd_hi, shamt_hi;
    logic [15:0] imm_hi;
    logic        fault_hi;

    int errors = 0;
    int checks = 0;
    int lat = 0;
    int wcnt = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] instr(input logic [31:0] a);
        return {a[7:2], a[25:0]} ^ 32'h0000_0020;
    endfunction

    cpu_ifetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .clrn(clrn), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
        .if_fault(if_fault)
    );

    cpu_ifetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_hi (
        .clk(clk), .clrn(clrn), .imem_req(req_hi), .imem_addr(addr_hi),
        .imem_ack(ack_hi), .imem_rdata(rdata_hi), .redir_valid(redir_hi),
        .redir_pc(redir_pc_hi), .id_valid(valid_hi), .id_ready(ready_hi), .id_pc(id_pc_hi),
        .op(op_hi), .func(func_hi), .rs(rs_hi), .rt(rt_hi), .rd(rd_hi), .shamt(shamt_hi),
        .imm(imm_hi), .if_fault(fault_hi)
    );

    assign ack_hi   = req_hi;
    assign rdata_hi = instr(addr_hi);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // memory model: ack after lat idle cycles of a raised request
    always @(negedge clk) begin
        if (!imem_req) begin
            wcnt = 0;
            imem_ack = 1'b0;
        end else if (wcnt >= lat) begin
            imem_ack = 1'b1;
            imem_rdata = instr(imem_addr);
            wcnt = 0;
        end else begin
            imem_ack = 1'b0;
            wcnt++;
        end
    end

    // scoreboard: every accepted instruction must match the queue head
    always @(negedge clk) begin : mon
        logic [31:0] e, w;
        if (clrn && id_valid && id_ready && !if_fault) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got id_pc %h expected none", id_pc);
            end else begin
                e = sb.pop_front();
                w = instr(e);
                chk("deliver_pc", id_pc, e);
                chk("deliver_fields", {op, rs, rt, rd, shamt, func}, w);
                chk("deliver_imm", {16'h0, imm}, {16'h0, w[15:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        id_ready = 1'b0;
        redir_valid = 1'b0;
        redir_pc = '0;
        clrn = 1'b0;
        lat = l;
        step();
        step();
    endtask

    task automatic wait_req_addr(input logic [31:0] a, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == a) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(nm, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (id_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(nm, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk(nm, sb.size(), 32'h0);
    endtask

    typedef struct {
        logic        clrn;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_id_pc;
        logic [5:0]  e_func;
        logic        e_hi_req;
        logic [31:0] e_hi_addr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [31:0] held_pc;
        logic [5:0]  held_func;

        tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h00, 1'b0, 32'hFFFF_FFFC};
        tbl[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 6'h00, 1'b1, 32'hFFFF_FFFC};
        tbl[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 6'h20, 1'b0, 32'hFFFF_FFFC};
        tbl[3] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 6'h20, 1'b1, 32'h0};
        tbl[4] = '{1'b1, 1'b0, 32'h4, 1'b1, 32'h4, 6'h24, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h4, 6'h24, 1'b1, 32'h4};
        tbl[6] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 6'h28, 1'b0, 32'h4};

        // zero-wait sequential fetch, one instruction per two cycles
        do_reset(0);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        for (int i = 0; i < 7; i++) begin
            clrn = tbl[i].clrn;
            id_ready = 1'b1;
            step();
            chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'h0, id_valid}, {31'h0, tbl[i].e_valid});
            chk($sformatf("v%0d_id_pc", i), id_pc, tbl[i].e_id_pc);
            chk($sformatf("v%0d_func", i), {26'h0, func}, {26'h0, tbl[i].e_func});
            chk($sformatf("v%0d_fault", i), {31'h0, if_fault}, 32'h0);
            chk($sformatf("v%0d_hi_req", i), {31'h0, req_hi}, {31'h0, tbl[i].e_hi_req});
            chk($sformatf("v%0d_hi_addr", i), addr_hi, tbl[i].e_hi_addr);
        end
        wait_empty("seq_drain");

        // slow memory plus controller stall
        do_reset(3);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        clrn = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'h0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, 32'h0);
            step();
        end
        wait_valid("slow_valid");
        chk("slow_id_pc", id_pc, 32'h0);
        held_pc = id_pc;
        held_func = func;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", {31'h0, id_valid}, 32'h1);
            chk("stall_id_pc", id_pc, held_pc);
            chk("stall_func", {26'h0, func}, {26'h0, held_func});
            chk("stall_req", {31'h0, imem_req}, 32'h0);
        end
        id_ready = 1'b1;
        wait_req_addr(held_pc + 32'h4, "stall_next_addr");
        wait_empty("stall_drain");

        // redirect while a request waits for its ack
        do_reset(3);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h100);
        clrn = 1'b1;
        id_ready = 1'b1;
        wait_req_addr(32'h8, "reach_addr8");
        redir_valid = 1'b1;
        redir_pc = 32'h100;
        step();
        redir_valid = 1'b0;
        chk("drop_addr_stable", imem_addr, 32'h8);
        chk("drop_req_high", {31'h0, imem_req}, 32'h1);
        wait_req_addr(32'h100, "drop_target_addr");
        wait_valid("drop_target_valid");
        chk("drop_target_id_pc", id_pc, 32'h100);
        wait_empty("drop_drain");

        // redirect coincident with ack, then redirect squashing a held instr
        do_reset(0);
        sb.push_back(32'h80);
        clrn = 1'b1;
        step();
        wait_req_addr(32'h0, "coinc_first_req");
        redir_valid = 1'b1;
        redir_pc = 32'h40;
        step();
        redir_valid = 1'b0;
        chk("coinc_req", {31'h0, imem_req}, 32'h1);
        chk("coinc_addr", imem_addr, 32'h40);
        chk("coinc_valid", {31'h0, id_valid}, 32'h0);
        wait_valid("coinc_valid_target");
        chk("coinc_id_pc", id_pc, 32'h40);
        step();
        redir_valid = 1'b1;
        redir_pc = 32'h80;
        step();
        redir_valid = 1'b0;
        chk("squash_valid", {31'h0, id_valid}, 32'h0);
        chk("squash_req", {31'h0, imem_req}, 32'h1);
        chk("squash_addr", imem_addr, 32'h80);
        id_ready = 1'b1;
        wait_empty("squash_drain");

        // reset asserted in the middle of a request
        do_reset(3);
        clrn = 1'b1;
        step();
        step();
        chk("midreq_req_before", {31'h0, imem_req}, 32'h1);
        clrn = 1'b0;
        step();
        chk("midreq_req", {31'h0, imem_req}, 32'h0);
        chk("midreq_valid", {31'h0, id_valid}, 32'h0);
        clrn = 1'b1;
        step();
        chk("midreq_restart_req", {31'h0, imem_req}, 32'h1);
        chk("midreq_restart_addr", imem_addr, 32'h0);

        // redirect to a misaligned target
        do_reset(0);
        clrn = 1'b1;
        wait_valid("mis_setup_valid");
        redir_valid = 1'b1;
        redir_pc = 32'h102;
        step();
        redir_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
        chk("fault_req", {31'h0, imem_req}, 32'h0);
        chk("fault_flag", {31'h0, if_fault}, 32'h1);
        chk("fault_valid", {31'h0, id_valid}, 32'h1);
        chk("fault_id_pc", id_pc, 32'h102);
        chk("fault_op", {26'h0, op}, 32'h0);
        id_ready = 1'b1;
        step();
        step();
        chk("fault_persist", {31'h0, if_fault}, 32'h1);
        chk("fault_persist_pc", id_pc, 32'h102);
        chk("fault_persist_req", {31'h0, imem_req}, 32'h0);
        id_ready = 1'b0;
        sb.push_back(32'h200);
        redir_valid = 1'b1;
        redir_pc = 32'h200;
        step();
        redir_valid = 1'b0;
        chk("fault_clear", {31'h0, if_fault}, 32'h0);
        chk("fault_clear_req", {31'h0, imem_req}, 32'h1);
        chk("fault_clear_addr", imem_addr, 32'h200);
        id_ready = 1'b1;
        wait_empty("fault_drain");
`else
        sb.push_back(32'h102);
        chk("mis_req", {31'h0, imem_req}, 32'h1);
        chk("mis_addr", imem_addr, 32'h102);
        chk("mis_fault", {31'h0, if_fault}, 32'h0);
        id_ready = 1'b1;
        wait_empty("mis_drain");
`endif

        id_ready = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_ifetch.md
Name: cpu_ifetch

Overview:
Instruction fetch stage directly upstream of the CPU control unit (cpuctr). Maintains the PC and fetches 32-bit MIPS words from instruction memory over a req/ack handshake. Holds each fetched word in an instruction register and presents the decoded fields (op, func, rs, rt, rd, shamt, imm) to the controller/decoder with a valid/ready handshake. Accepts PC redirects from branch/jump resolution.

Parameters:
ADDR_W, 32, PC and instruction address width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on rising edge
clrn  input  1  synchronous active-low reset; sampled on clk rising edge
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  ADDR_W  fetch address; stable while imem_req high
imem_ack  input  1  memory response valid; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
redir_valid  input  1  redirect PC (branch/jump taken)
redir_pc  input  ADDR_W  redirect target
id_valid  output  1  instruction register holds a valid instruction
id_ready  input  1  controller accepts instruction this cycle
id_pc  output  ADDR_W  address of the held instruction
op  output  6  IR[31:26]
func  output  6  IR[5:0]
rs  output  5  IR[25:21]
rt  output  5  IR[20:16]
rd  output  5  IR[15:11]
shamt  output  5  IR[10:6]
imm  output  16  IR[15:0]
if_fault  output  1  misaligned-PC fault (only with IFETCH_ALIGN_CHK_EN; else constant 0)

Behaviour:
- Reset (clrn=0 at a clk edge): pc=RESET_PC, req_addr=RESET_PC, IR=0, id_pc=0, state=IDLE, drop=0, id_valid=0, imem_req=0, if_fault=0. All field outputs therefore 0. Reset overrides everything, including mid-request; memory must tolerate request withdrawal on reset only.
- Fields are pure combinational slices of IR; id_pc is a register captured with IR.
- States: IDLE, REQ, HOLD.
- IDLE: imem_req=0; next edge -> REQ with req_addr=pc. Minimum reset-release to first imem_req: 1 cycle.
- REQ: imem_req=1, imem_addr=req_addr. On edge with imem_ack=1 and drop=0 and no redir: IR<=imem_rdata, id_pc<=req_addr, pc<=req_addr+4, id_valid<=1, -> HOLD. Without ack: stay REQ, address stable.
- HOLD: imem_req=0, id_valid=1, outputs stable while id_ready=0 (stall of any length). On edge with id_ready=1: id_valid<=0, req_addr<=pc, -> REQ. Throughput: at best one instruction per 2 cycles with zero-wait memory.
- PC increment is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect (redir_valid=1 at an edge), priority over all except reset:
  - IDLE: pc<=redir_pc; -> REQ with req_addr=redir_pc.
  - REQ, no ack: pc<=redir_pc, drop<=1; imem_addr remains old address until ack.
  - REQ with ack same edge: response discarded, pc<=redir_pc, req_addr<=redir_pc, drop<=0, stay REQ.
  - REQ, ack with drop=1 (no new redir): response discarded, drop<=0, req_addr<=pc, stay REQ (new request issued next cycle, imem_req continuously high).
  - HOLD: id_valid<=0, pc<=redir_pc, req_addr<=redir_pc, -> REQ. If id_ready=1 the same cycle, the transfer counts as completed; otherwise the held instruction is squashed.
- Second redirect while drop=1: pc takes the newest target; drop stays 1.
- imem_ack while imem_req=0 is ignored.

Optional Feature:
IFETCH_ALIGN_CHK_EN. Defined: before leaving IDLE/entering REQ, if the next req_addr[1:0]!=0, no request is issued; state -> HOLD with id_valid=1, IR=0 (op=0/func=0, nop), id_pc=faulting address, if_fault=1. The controller consumes it via id_ready like a normal instruction; only a redirect or reset leaves the fault (further id_ready re-presents the same fault). if_fault clears on redirect/reset. Not defined: address bits [1:0] are passed through unchecked and if_fault is tied 0.

Test Plan:
- Reset then zero-wait memory returning 32'h0000_0020 (add) at 0x0, id_ready=1 -> imem_addr 0x0,0x4,0x8 in sequence; op=0, func=6'h20, id_pc=0x0; id_valid every 2nd cycle.
- 3-cycle ack latency plus id_ready low 4 cycles -> imem_addr stable during wait; IR/id_pc unchanged during stall; next fetch at id_pc+4.
- redir_valid (target 0x100) during REQ awaiting ack for 0x8 -> that ack's data never reaches id_valid; next imem_addr=0x100; id_pc=0x100.
- redir_valid coincident with imem_ack, and redirect during HOLD with id_ready=0 -> data discarded/squashed, next fetch at target.
- RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0; clrn=0 asserted mid-REQ -> imem_req=0, id_valid=0 next cycle, restart at RESET_PC.
- With IFETCH_ALIGN_CHK_EN, redirect to 0x102 -> no imem_req, if_fault=1, id_pc=0x102, op=0; redirect to 0x200 clears fault and fetches.
